// File: rtl/dec2bin_if.sv
// Request/result bundle for the sequential BCD-to-binary converter.
// Level handshake: start is sampled only while done=1 in IDLE; done drops on the capture edge and
// rises together with valid dout/err; start must return low before another conversion can begin.
interface dec2bin_if #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 16
);
  logic                  start;
  logic [4*DIGITS-1:0]   din;
  logic                  done;
  logic [OUT_W-1:0]      dout;
  logic                  err;
  logic [1:0]            fsm_state;

  modport master (output start, din, input done, dout, err, fsm_state);
  modport slave  (input start, din, output done, dout, err, fsm_state);
endinterface

// File: rtl/dec2bin.sv
// Packed BCD to unsigned binary, one digit per clock, MSD first, acc = acc*10 + digit.
// Digits above 9 are clamped to 9 and reported on err for that conversion.
module dec2bin #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 16
) (
  input  logic     clk,
  input  logic     rst,
  dec2bin_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int SR_W = 4 * DIGITS;

  state_t            state, state_nx;
  logic [SR_W-1:0]   sr;
  logic [OUT_W-1:0]  acc;
  logic [OUT_W-1:0]  acc_next;
  logic [2:0]        cnt;
  logic              err_acc;
  logic [OUT_W-1:0]  dout_r;
  logic              err_r;
  logic [3:0]        digit;
  logic [3:0]        digit_eff;
  logic              digit_bad;
  logic              last;

  assign digit     = sr[SR_W-1 -: 4];
  assign digit_bad = (digit > 4'd9);
  assign digit_eff = digit_bad ? 4'd9 : digit;
  assign acc_next  = (acc << 3) + (acc << 1) + OUT_W'(digit_eff);
  assign last      = (cnt == 3'(DIGITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = ACCUM;
      ACCUM:   if (last)      state_nx = HOLD;
      HOLD:    if (!bus.start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      acc     <= '0;
      cnt     <= '0;
      err_acc <= 1'b0;
      dout_r  <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sr      <= bus.din;
            acc     <= '0;
            cnt     <= '0;
            err_acc <= 1'b0;
          end
        end
        ACCUM: begin
          acc     <= acc_next;
          sr      <= sr << 4;
          cnt     <= cnt + 3'd1;
          err_acc <= err_acc | digit_bad;
          // Outputs move only on the final digit so no partial result is ever visible.
          if (last) begin
            dout_r <= acc_next;
            err_r  <= err_acc | digit_bad;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.done      = (state == IDLE) || (state == HOLD);
  assign bus.dout      = dout_r;
  assign bus.err       = err_r;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_dec2bin.sv
// Directed bench for dec2bin: 4-digit default instance plus a 2-digit / 8-bit instance.
module tb_dec2bin;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dec2bin_if #(.DIGITS(4), .OUT_W(16)) bus  ();
  dec2bin_if #(.DIGITS(2), .OUT_W(8))  bus2 ();

  dec2bin #(.DIGITS(4), .OUT_W(16)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  dec2bin #(.DIGITS(2), .OUT_W(8))  u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Leaves start high; the caller releases it with release_start.
  task automatic convert(input logic [15:0] v, input logic [15:0] exp_d,
                         input logic exp_e, input string tag);
    logic [15:0] prev;
    @(negedge clk);
    bus.din   = v;
    bus.start = 1'b1;
    prev      = bus.dout;
    @(posedge clk); #1;
    check({tag, " busy0"}, 32'(bus.done), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin
        check({tag, " busy"}, 32'(bus.done), 32'd0);
        check({tag, " dout held"}, 32'(bus.dout), 32'(prev));
      end else begin
        check({tag, " done"}, 32'(bus.done), 32'd1);
        check({tag, " dout"}, 32'(bus.dout), 32'(exp_d));
        check({tag, " err"}, 32'(bus.err), 32'(exp_e));
        check({tag, " hold st"}, 32'(bus.fsm_state), 32'd2);
      end
    end
  endtask

  task automatic release_start(input logic [15:0] exp_d, input string tag);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check({tag, " idle st"}, 32'(bus.fsm_state), 32'd0);
    check({tag, " idle done"}, 32'(bus.done), 32'd1);
    check({tag, " idle dout"}, 32'(bus.dout), 32'(exp_d));
  endtask

  task automatic convert2(input logic [7:0] v, input logic [7:0] exp_d,
                          input logic exp_e, input string tag);
    @(negedge clk);
    bus2.din   = v;
    bus2.start = 1'b1;
    @(posedge clk); #1;
    check({tag, " busy0"}, 32'(bus2.done), 32'd0);
    @(posedge clk); #1;
    check({tag, " busy1"}, 32'(bus2.done), 32'd0);
    @(posedge clk); #1;
    check({tag, " done"}, 32'(bus2.done), 32'd1);
    check({tag, " dout"}, 32'(bus2.dout), 32'(exp_d));
    check({tag, " err"}, 32'(bus2.err), 32'(exp_e));
    @(negedge clk);
    bus2.start = 1'b0;
    @(posedge clk); #1;
    check({tag, " idle"}, 32'(bus2.fsm_state), 32'd0);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.din    = '0;
    bus2.start = 1'b0;
    bus2.din   = '0;

    #2;
    check("rst done", 32'(bus.done), 32'd1);
    check("rst dout", 32'(bus.dout), 32'd0);
    check("rst err",  32'(bus.err),  32'd0);
    check("rst done2", 32'(bus2.done), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    convert(16'h1234, 16'h04D2, 1'b0, "c1234");
    release_start(16'h04D2, "c1234");
    convert(16'h9999, 16'h270F, 1'b0, "c9999");
    release_start(16'h270F, "c9999");
    convert(16'h0000, 16'h0000, 1'b0, "c0000");
    release_start(16'h0000, "c0000");
    convert(16'h12A4, 16'h050E, 1'b1, "c12A4");
    release_start(16'h050E, "c12A4");
    convert(16'h0007, 16'h0007, 1'b0, "c0007");
    release_start(16'h0007, "c0007");

    // start held high: one conversion, then parked in HOLD
    convert(16'h0042, 16'h002A, 1'b0, "c0042");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("hold done", 32'(bus.done), 32'd1);
      check("hold dout", 32'(bus.dout), 32'h2A);
    end
    release_start(16'h002A, "c0042");

    // din and start disturbed mid-conversion
    @(negedge clk);
    bus.din   = 16'h0042;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.din   = 16'h0099;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check("dist busy", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    check("dist done", 32'(bus.done), 32'd1);
    check("dist dout", 32'(bus.dout), 32'h2A);
    release_start(16'h002A, "dist");

    // async reset during the second ACCUM cycle
    @(negedge clk);
    bus.din   = 16'h5555;
    bus.start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst done", 32'(bus.done), 32'd1);
    check("arst dout", 32'(bus.dout), 32'd0);
    check("arst err",  32'(bus.err),  32'd0);
    check("arst st",   32'(bus.fsm_state), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b0;
    convert(16'h0100, 16'h0064, 1'b0, "c0100");
    release_start(16'h0064, "c0100");

    convert2(8'h99, 8'h63, 1'b0, "d2_99");
    convert2(8'hF0, 8'h5A, 1'b1, "d2_F0");
    convert2(8'h05, 8'h05, 1'b0, "d2_05");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/dec2bin.md
Name: dec2bin

Overview:
- Converts a packed BCD word (most significant digit in the upper nibble) into an unsigned binary value.
- Operates sequentially, one digit per clock, using shift-add multiply-by-10.
- Sits between user-entered or display-side decimal fields (keypad/OLED setpoint entry) and the binary control datapath.
- Uses the same level start/done handshake as the binary-to-decimal display converter, so both blocks share one controller style.

Parameters:
DIGITS, 4, number of BCD digits in din; legal range 1..4
OUT_W, 16, width of dout; must satisfy 10^DIGITS-1 < 2^OUT_W

Ports:
clk    input   1          system clock, all state on rising edge
rst    input   1          asynchronous, active-high reset
start  input   1          level request; sampled only in IDLE
din    input   4*DIGITS   packed BCD input; digit k in din[4k+3:4k], digit DIGITS-1 most significant
done   output  1          high in IDLE and HOLD, low while converting
dout   output  OUT_W      binary result, registered
err    output  1          registered; high if any digit of the last conversion was > 9

Behaviour:
- States: IDLE, ACCUM, HOLD.
- done = (state==IDLE || state==HOLD), decoded combinationally from the state register.
- Reset (async, rst=1):
  - state=IDLE, dout=0, err=0.
  - Internal accumulator, digit shift register, digit counter and error latch all cleared.
  - done=1 immediately, with no clock edge needed.
- IDLE: on an edge with start=1:
  - capture din into the digit shift register;
  - clear acc=0, cnt=0, err_acc=0;
  - go to ACCUM.
  - With start=0: remain in IDLE; dout and err hold.
- ACCUM, one digit per edge, MSD first:
  - d = top nibble of the shift register; if d>9 then d_eff=9 and err_acc is set, else d_eff=d.
  - acc <= (acc<<3) + (acc<<1) + d_eff, computed at OUT_W bits; no overflow is possible given the parameter rule.
  - Shift register moves left by 4; cnt increments.
  - On the edge where cnt==DIGITS-1:
    - dout <= final accumulated value;
    - err <= err_acc OR (d>9) for the current digit;
    - go to HOLD.
- Latency: start captured at edge E0 → done low from E0 → dout/err valid and done high after edge E0+DIGITS (4 conversion edges at the default).
- HOLD: remain while start=1; on an edge with start=0 go to IDLE.
  - A new conversion needs start to go low then high again, so holding start high yields exactly one conversion.
- dout and err hold their previous values throughout ACCUM and update only on the final ACCUM edge.
- din changes after the capture edge are ignored.
- start toggling during ACCUM is ignored; the conversion always completes.
- rst asserted mid-conversion aborts immediately to IDLE with dout=0, err=0. No partial result is ever presented.
- Upper dout bits above the 10^DIGITS range are always 0.
- Invalid digits (A–F): clamped to 9 in the result and flagged on err.

Test Plan:
- Reset, then din=16'h1234, start pulsed high and held: done=0 for 4 cycles → dout=16'h04D2 (1234), err=0, done=1; start low → IDLE, dout holds 16'h04D2.
- din=16'h9999 → dout=16'h270F (9999), err=0; then din=16'h0000 → dout=16'h0000, err=0, latency exactly 4 edges.
- din=16'h12A4 → dout=16'h050E (1294, A clamped to 9), err=1; next conversion with 16'h0007 → dout=16'h0007, err cleared to 0.
- start held high 20 cycles with din=16'h0042: exactly one conversion, dout=16'h002A stable, done=1 throughout HOLD. Change din to 16'h0099 mid-ACCUM in a second run started with 16'h0042: result still 16'h002A.
- rst asserted asynchronously (between clock edges) during the 2nd ACCUM cycle of din=16'h5555: done=1, dout=0, err=0 before the next edge. After release, start with 16'h0100 → dout=16'h0064.
- DIGITS=2, OUT_W=8: din=8'h99 → dout=8'h63 after 2 edges; din=8'hF0 → dout=8'h5A (90), err=1.
